// File: rtl/time_display_pkg.sv
// Shared constants and types for the time display scanner: digit count,
// segment codes, separator positions, digit index type and a BCD split helper.
package time_display_pkg;

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned BIN_W      = 6;
  localparam int unsigned BCD_W      = 4;

  // Active-high segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0   = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1   = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2   = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3   = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4   = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5   = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6   = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7   = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8   = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9   = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

  typedef logic [2:0] digit_idx_t;

  // Separator dots follow minutes-units and hours-units
  localparam digit_idx_t DP_IDX_MIN = 3'd2;
  localparam digit_idx_t DP_IDX_HR  = 3'd4;
  localparam digit_idx_t LAST_IDX   = 3'(NUM_DIGITS - 1);

  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] units;
  } bcd_t;

  // Split a 0..63 binary value into tens and units; no clamping
  function automatic bcd_t bcd_split(input logic [BIN_W-1:0] v);
    bcd_t r;
    r.tens  = BCD_W'(v / 6'd10);
    r.units = BCD_W'(v % 6'd10);
    return r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to 7-segment decoder with blanking and selectable
// output polarity. Codes 10..15 decode to all segments off.
module seg7_decode
  import time_display_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic [BCD_W-1:0] bcd,
  input  logic             blank,
  output logic [SEG_W-1:0] seg_c
);

  logic [SEG_W-1:0] code;

  // Look up the active-high code, then apply panel polarity
  always_comb begin
    code = SEG_OFF;
    if (!blank) begin
      case (bcd)
        4'd0:    code = SEG_0;
        4'd1:    code = SEG_1;
        4'd2:    code = SEG_2;
        4'd3:    code = SEG_3;
        4'd4:    code = SEG_4;
        4'd5:    code = SEG_5;
        4'd6:    code = SEG_6;
        4'd7:    code = SEG_7;
        4'd8:    code = SEG_8;
        4'd9:    code = SEG_9;
        default: code = SEG_OFF;
      endcase
    end
    seg_c = ACTIVE_LOW ? ~code : code;
  end

endmodule

// File: rtl/time_display_scan.sv
// Six-digit multiplexed time display: snapshots hours/minutes/seconds on
// update, splits each to BCD and scans one digit per slot with a one-cycle
// blank at the start of every slot. Optional macro LEADING_ZERO_BLANK_EN
// suppresses the segments of a zero hours-tens digit.
module time_display_scan
  import time_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DIV_WIDTH      = 10,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [BIN_W-1:0]      hours,
  input  logic [BIN_W-1:0]      minutes,
  input  logic [BIN_W-1:0]      seconds,
  input  logic                  update,
  output logic [SEG_W-1:0]      seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] digit_sel
);

  localparam logic [DIV_WIDTH-1:0] CNT_LAST = DIV_WIDTH'(SCAN_DIV - 1);
  localparam logic [SEG_W-1:0]     SEG_IDLE = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic                 DP_IDLE  = SEG_ACTIVE_LOW;

  logic [BIN_W-1:0]      hr_q, min_q, sec_q;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  digit_idx_t            idx_q, idx_d;

  bcd_t                  hr_b, min_b, sec_b;
  logic [BCD_W-1:0]      digit;
  logic                  drive;
  logic                  blank_digit;
  logic [SEG_W-1:0]      seg_dec_c;
  logic                  dp_d;
  logic [NUM_DIGITS-1:0] sel_d;

  // Coherent capture of the three counters on the update strobe
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hr_q  <= '0;
      min_q <= '0;
      sec_q <= '0;
    end else if (update) begin
      hr_q  <= hours;
      min_q <= minutes;
      sec_q <= seconds;
    end
  end

  // Slot prescaler and digit index registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Next prescaler count; index advances on the last cycle of each slot
  always_comb begin
    cnt_d = cnt_q + DIV_WIDTH'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 3'd1;
    end
  end

  // Select the digit for the current index and form next output values
  always_comb begin
    hr_b  = bcd_split(hr_q);
    min_b = bcd_split(min_q);
    sec_b = bcd_split(sec_q);
    digit = '0;
    case (idx_q)
      3'd0:    digit = sec_b.units;
      3'd1:    digit = sec_b.tens;
      3'd2:    digit = min_b.units;
      3'd3:    digit = min_b.tens;
      3'd4:    digit = hr_b.units;
      3'd5:    digit = hr_b.tens;
      default: digit = '0;
    endcase
    drive       = (cnt_q != '0);
    blank_digit = !drive;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx_q == LAST_IDX && hr_b.tens == '0) blank_digit = 1'b1;
`endif
    dp_d  = (drive && (idx_q == DP_IDX_MIN || idx_q == DP_IDX_HR)) ^ SEG_ACTIVE_LOW;
    sel_d = drive ? (NUM_DIGITS'(1) << idx_q) : '0;
  end

  seg7_decode #(
    .ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_decode (
    .bcd   (digit),
    .blank (blank_digit),
    .seg_c (seg_dec_c)
  );

  // Registered panel outputs, one cycle behind the scan state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seg       <= SEG_IDLE;
      dp        <= DP_IDLE;
      digit_sel <= '0;
    end else begin
      seg       <= seg_dec_c;
      dp        <= dp_d;
      digit_sel <= sel_d;
    end
  end

endmodule

// File: tb/tb_time_display_scan.sv
// Bench for time_display_scan with SCAN_DIV=4: a frame-position model checked
// every cycle, plus directed slot checks with hand-derived segment codes.
module tb_time_display_scan;

  localparam int SD    = 4;
  localparam int FRAME = 6 * SD;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] hours = '0, minutes = '0, seconds = '0;
  logic       update = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] digit_sel;

  int errors = 0;
  int checks = 0;

  time_display_scan #(
    .SCAN_DIV       (SD),
    .DIV_WIDTH      (10),
    .SEG_ACTIVE_LOW (1'b0)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .hours     (hours),
    .minutes   (minutes),
    .seconds   (seconds),
    .update    (update),
    .seg       (seg),
    .dp        (dp),
    .digit_sel (digit_sel)
  );

  initial forever #5 clock = ~clock;

  function automatic logic [6:0] seg_of(int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
      4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
      8: return 7'h7F; 9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Expected {seg,dp,digit_sel} for frame position pos given a snapshot
  function automatic logic [13:0] model_out(int pos, logic [5:0] h, logic [5:0] m, logic [5:0] s);
    int idx;
    int c;
    int d;
    logic [6:0] sg;
    logic       dpv;
    logic [5:0] sel;
    idx = pos / SD;
    c   = pos % SD;
    if (c == 0) return 14'h0;
    case (idx)
      0: d = int'(s) % 10;
      1: d = int'(s) / 10;
      2: d = int'(m) % 10;
      3: d = int'(m) / 10;
      4: d = int'(h) % 10;
      default: d = int'(h) / 10;
    endcase
    sg = seg_of(d);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx == 5 && int'(h) / 10 == 0) sg = 7'h00;
`endif
    dpv = (idx == 2 || idx == 4);
    sel = 6'(1 << idx);
    return {sg, dpv, sel};
  endfunction

  logic [13:0] exp_q = '0;
  int          pos_m = 0;
  logic [5:0]  h_m = '0, m_m = '0, s_m = '0;

  // Reference model: frame position since reset plus snapshot
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      exp_q <= '0;
      pos_m <= 0;
      h_m   <= '0;
      m_m   <= '0;
      s_m   <= '0;
    end else begin
      exp_q <= model_out(pos_m, h_m, m_m, s_m);
      pos_m <= (pos_m + 1) % FRAME;
      if (update) begin
        h_m <= hours;
        m_m <= minutes;
        s_m <= seconds;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Wait for a blank then the first cycle of the target slot
  task automatic wait_sel(input logic [5:0] target, output bit ok);
    bit seen_blank;
    seen_blank = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge clock);
      if (digit_sel == 6'h00) seen_blank = 1'b1;
      else if (seen_blank && digit_sel == target) ok = 1'b1;
    end
  endtask

  task automatic check_slot(input string name, input int idx, input logic [6:0] s_want, input logic dp_want);
    bit ok;
    wait_sel(6'(1 << idx), ok);
    if (ok) begin
      chk({name, "_seg"}, 32'(seg), 32'(s_want));
      chk({name, "_dp"}, 32'(dp), 32'(dp_want));
    end else begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
    end
  endtask

  task automatic pulse(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
    @(negedge clock);
    hours   = h;
    minutes = m;
    seconds = s;
    update  = 1'b1;
    @(negedge clock);
    update  = 1'b0;
  endtask

  initial begin
    logic [5:0] w;
    bit         has;
    bit         ok;
    bit         found;
    int         cur;
    logic [6:0] nt [6];
    logic [6:0] hz;

`ifdef LEADING_ZERO_BLANK_EN
    hz = 7'h00;
`else
    hz = 7'h3F;
`endif
    nt[0] = 7'h4F; nt[1] = 7'h3F; nt[2] = 7'h5B;
    nt[3] = 7'h3F; nt[4] = 7'h06; nt[5] = hz;

    fork
      forever begin
        @(negedge clock);
        chk("scan", {18'b0, seg, dp, digit_sel}, {18'b0, exp_q});
        chk("onehot", 32'($countones(digit_sel) <= 1), 32'd1);
      end
    join_none

    // Reset held with inputs toggling
    #1 reset = 1'b0;
    repeat (6) begin
      @(negedge clock);
      hours   = 6'($urandom_range(0, 63));
      minutes = 6'($urandom_range(0, 63));
      seconds = 6'($urandom_range(0, 63));
      update  = ~update;
    end
    chk("rst_seg", 32'(seg), 32'h0);
    chk("rst_dp", 32'(dp), 32'h0);
    chk("rst_sel", 32'(digit_sel), 32'h0);
    update = 1'b0;
    reset  = 1'b1;

    // Slot timing from reset release with zero snapshot
    for (int e = 1; e <= 26; e++) begin
      @(negedge clock);
      has = 1'b1;
      w   = '0;
      case (e)
        1, 5, 25:    w = 6'h00;
        2, 3, 4, 26: w = 6'h01;
        6, 7, 8:     w = 6'h02;
        24:          w = 6'h20;
        default:     has = 1'b0;
      endcase
      if (has) chk($sformatf("edge%0d_sel", e), 32'(digit_sel), 32'(w));
    end

    // 12:34:56
    pulse(6'd12, 6'd34, 6'd56);
    check_slot("t3_s_u", 0, 7'h7D, 1'b0);
    check_slot("t3_s_t", 1, 7'h6D, 1'b0);
    check_slot("t3_m_u", 2, 7'h66, 1'b1);
    check_slot("t3_m_t", 3, 7'h4F, 1'b0);
    check_slot("t3_h_u", 4, 7'h5B, 1'b1);
    check_slot("t3_h_t", 5, 7'h06, 1'b0);

    // Inputs change without update: display holds
    @(negedge clock);
    hours = 6'd1; minutes = 6'd2; seconds = 6'd3;
    repeat (2 * FRAME) @(negedge clock);
    check_slot("hold_s_u", 0, 7'h7D, 1'b0);
    check_slot("hold_m_u", 2, 7'h66, 1'b1);
    pulse(6'd1, 6'd2, 6'd3);
    @(negedge clock);
    ok = 1'b0;
    found = 1'b0;
    cur = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (digit_sel == 6'h00) ok = 1'b1;
      else if (ok) begin
        found = 1'b1;
        for (int b = 0; b < 6; b++) if (digit_sel[b]) cur = b;
      end
    end
    if (found) chk("t4_next_seg", 32'(seg), 32'(nt[cur]));
    else       chk("t4_next_timeout", 32'd0, 32'd1);

    // Out-of-range hours shown as-is
    pulse(6'd63, 6'd0, 6'd9);
    check_slot("t5_s_u", 0, 7'h6F, 1'b0);
    check_slot("t5_m_t", 3, 7'h3F, 1'b0);
    check_slot("t5_h_u", 4, 7'h4F, 1'b1);
    check_slot("t5_h_t", 5, 7'h7D, 1'b0);

    // Reset mid-slot at idx 3, cnt 2
    wait_sel(6'h08, ok);
    chk("t6_reach_idx3", 32'(ok), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_sel", 32'(digit_sel), 32'h0);
    chk("t6_rst_seg", 32'(seg), 32'h0);
    chk("t6_rst_dp", 32'(dp), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("t6_edge1_sel", 32'(digit_sel), 32'h00);
    @(negedge clock);
    chk("t6_edge2_sel", 32'(digit_sel), 32'h01);
    chk("t6_edge2_seg", 32'(seg), 32'h3F);
    pulse(6'd5, 6'd0, 6'd0);
    check_slot("t6_h_t", 5, hz, 1'b0);
    check_slot("t6_h_u", 4, 7'h6D, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
